// File: rtl/cc_branch_unit_if.sv
// Branch request / redirect bundle between decode-execute, the branch unit and the fetch PC mux.
interface cc_branch_unit_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned OFFSET_W = 9
);
    logic                br_valid;
    logic                br_ready;
    logic [2:0]          br_mask;
    logic [DATA_W-1:0]   br_pc;
    logic [OFFSET_W-1:0] br_offset;
    logic                redirect_valid;
    logic [DATA_W-1:0]   redirect_pc;
    logic                flush;

    modport master (
        output br_valid, br_mask, br_pc, br_offset,
        input  br_ready, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  br_valid, br_mask, br_pc, br_offset,
        output br_ready, redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/cc_branch_unit.sv
// Condition-code register plus BRnzp branch resolution; issues a one-cycle fetch redirect
// followed by a fixed-length flush window for every taken branch.
module cc_branch_unit #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned OFFSET_W     = 9,
    parameter int unsigned FLUSH_CYCLES = 2   // 1..15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we_i,
    input  logic            alu_n_i,
    input  logic            alu_z_i,
    input  logic            alu_p_i,
    cc_branch_unit_if.slave br,
    output logic            cc_n_o,
    output logic            cc_z_o,
    output logic            cc_p_o,
    output logic [15:0]     taken_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        cc_q, cc_d;
    logic [2:0]        flags_in, flags_clean;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [DATA_W-1:0] off_ext, target;
    logic              redirect_valid_q, redirect_valid_d;
    logic              flush_q, flush_d;
    logic [15:0]       taken_cnt_q, taken_cnt_d;
    logic              accept, taken;

    assign flags_in = {alu_n_i, alu_z_i, alu_p_i};

    // Anything other than exactly one flag set collapses to Z.
    always_comb begin
        flags_clean = 3'b010;
        if (flags_in == 3'b100 || flags_in == 3'b010 || flags_in == 3'b001) begin
            flags_clean = flags_in;
        end
    end

    // cc_d doubles as the bypassed CC seen by a branch in the same cycle as a flag write.
    assign cc_d   = flag_we_i ? flags_clean : cc_q;
    assign taken  = |(br.br_mask & cc_d);

    assign br.br_ready = (state_q == StIdle);
    assign accept      = br.br_valid && br.br_ready;

    assign off_ext = {{(DATA_W - OFFSET_W){br.br_offset[OFFSET_W-1]}}, br.br_offset};
    assign target  = br.br_pc + DATA_W'(1) + off_ext;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        taken_cnt_d   = taken_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept && taken) begin
                    state_d       = StRedirect;
                    redirect_pc_d = target;
                    taken_cnt_d   = (taken_cnt_q == 16'hFFFF) ? taken_cnt_q : taken_cnt_q + 16'd1;
                end
            end
            StRedirect: begin
                cnt_d   = 4'(FLUSH_CYCLES - 1);
                state_d = (cnt_d == 4'd0) ? StIdle : StFlush;
            end
            StFlush: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered copies of the next-state decode keep the outputs glitch-free.
        redirect_valid_d = (state_d == StRedirect);
        flush_d          = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            cnt_q            <= 4'd0;
            cc_q             <= 3'b010;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            taken_cnt_q      <= 16'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cc_q             <= cc_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    assign br.redirect_valid = redirect_valid_q;
    assign br.redirect_pc    = redirect_pc_q;
    assign br.flush          = flush_q;
    assign cc_n_o            = cc_q[2];
    assign cc_z_o            = cc_q[1];
    assign cc_p_o            = cc_q[0];
    assign taken_cnt_o       = taken_cnt_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit: expected redirect targets go through a scoreboard queue.
module tb_cc_branch_unit;
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 9;
    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_we, alu_n, alu_z, alu_p;
    logic        cc_n, cc_z, cc_p;
    logic [15:0] taken_cnt;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_push   = 0;
    int n_pulse  = 0;
    int n_double = 0;
    logic rv_prev = 1'b0;
    logic [DW-1:0] sb[$];

    cc_branch_unit_if #(.DATA_W(DW), .OFFSET_W(OW)) bif ();

    cc_branch_unit #(.DATA_W(DW), .OFFSET_W(OW), .FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flag_we_i   (flag_we),
        .alu_n_i     (alu_n),
        .alu_z_i     (alu_z),
        .alu_p_i     (alu_p),
        .br          (bif.slave),
        .cc_n_o      (cc_n),
        .cc_z_o      (cc_z),
        .cc_p_o      (cc_p),
        .taken_cnt_o (taken_cnt)
    );

    always #5 clk = ~clk;

    // Counts redirect pulses and flags any pulse longer than one cycle.
    always @(negedge clk) begin
        if (bif.redirect_valid) n_pulse <= n_pulse + 1;
        if (bif.redirect_valid && rv_prev) n_double <= n_double + 1;
        rv_prev <= bif.redirect_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_flags(input logic [2:0] f);
        flag_we = 1'b1;
        {alu_n, alu_z, alu_p} = f;
        @(negedge clk);
        flag_we = 1'b0;
    endtask

    task automatic wait_redirect(input string tag);
        int waited = 0;
        logic [DW-1:0] exp_pc;
        while (!bif.redirect_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "/latency"}, waited, 0);
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, "/redirect_pc"}, {16'h0, bif.redirect_pc}, {16'h0, exp_pc});
    endtask

    // Drives a branch for one cycle (caller may pre-set flag_we for bypass) and checks the window.
    task automatic take_branch(input string tag, input logic [2:0] mask, input logic [DW-1:0] pc,
                               input logic [OW-1:0] off, input logic [DW-1:0] exp_pc);
        bif.br_valid = 1'b1;
        bif.br_mask = mask;
        bif.br_pc = pc;
        bif.br_offset = off;
        sb.push_back(exp_pc);
        n_push++;
        @(negedge clk);
        bif.br_valid = 1'b0;
        flag_we = 1'b0;
        wait_redirect(tag);
        for (int i = 0; i < int'(FC); i++) begin
            check({tag, "/flush_hi"}, bif.flush, 1);
            check({tag, "/ready_lo"}, bif.br_ready, 0);
            if (i > 0) check({tag, "/rv_drop"}, bif.redirect_valid, 0);
            @(negedge clk);
        end
        check({tag, "/flush_end"}, bif.flush, 0);
        check({tag, "/ready_back"}, bif.br_ready, 1);
    endtask

    task automatic not_taken(input string tag, input logic [2:0] mask, input logic [DW-1:0] pc);
        bif.br_valid = 1'b1;
        bif.br_mask = mask;
        bif.br_pc = pc;
        bif.br_offset = 9'h004;
        @(negedge clk);
        bif.br_valid = 1'b0;
        flag_we = 1'b0;
        check({tag, "/rv"}, bif.redirect_valid, 0);
        check({tag, "/flush"}, bif.flush, 0);
        check({tag, "/ready"}, bif.br_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        flag_we = 1'b0;
        {alu_n, alu_z, alu_p} = 3'b000;
        bif.br_valid = 1'b0;
        bif.br_mask = 3'b000;
        bif.br_pc = '0;
        bif.br_offset = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst/cc", {cc_n, cc_z, cc_p}, 3'b010);
        check("rst/ready", bif.br_ready, 1);
        check("rst/flush", bif.flush, 0);
        check("rst/rv", bif.redirect_valid, 0);
        check("rst/pc", bif.redirect_pc, 0);
        check("rst/cnt", taken_cnt, 0);

        // N flag then BRn
        write_flags(3'b100);
        check("n/cc", {cc_n, cc_z, cc_p}, 3'b100);
        take_branch("brn", 3'b100, 16'h3000, 9'h005, 16'h3006);
        check("brn/cnt", taken_cnt, 1);

        // Bypass: CC=Z, same-cycle flag write of P makes mask 101 taken
        write_flags(3'b010);
        flag_we = 1'b1;
        {alu_n, alu_z, alu_p} = 3'b001;
        take_branch("bypass", 3'b101, 16'h1234, 9'h010, 16'h1245);
        check("bypass/cc", {cc_n, cc_z, cc_p}, 3'b001);
        check("bypass/cnt", taken_cnt, 2);

        // Same branch without the flag write sees the old Z and falls through
        write_flags(3'b010);
        not_taken("nobypass", 3'b101, 16'h1234);
        check("nobypass/cnt", taken_cnt, 2);
        check("nobypass/pc_hold", bif.redirect_pc, 16'h1245);

        // Offset sign extension and wrap-around
        take_branch("neg1", 3'b111, 16'h0000, 9'h1FF, 16'h0000);
        take_branch("neg256", 3'b111, 16'h0010, 9'h100, 16'hFF11);
        take_branch("wrap", 3'b111, 16'hFFFF, 9'h000, 16'h0000);
        check("wrap/cnt", taken_cnt, 5);

        // Back-to-back never-taken branches with br_valid held high
        bif.br_valid = 1'b1;
        bif.br_mask = 3'b000;
        for (int i = 0; i < 4; i++) begin
            bif.br_pc = 16'h4000 + 16'(i);
            check("b2b/ready", bif.br_ready, 1);
            @(negedge clk);
            check("b2b/flush", bif.flush, 0);
            check("b2b/rv", bif.redirect_valid, 0);
        end
        bif.br_valid = 1'b0;
        check("b2b/cnt", taken_cnt, 5);

        // Illegal flag pattern collapses to Z
        write_flags(3'b001);
        check("legal/cc", {cc_n, cc_z, cc_p}, 3'b001);
        write_flags(3'b110);
        check("illegal/cc", {cc_n, cc_z, cc_p}, 3'b010);

        // Async reset in the middle of the flush window
        bif.br_valid = 1'b1;
        bif.br_mask = 3'b010;
        bif.br_pc = 16'h0100;
        bif.br_offset = 9'h002;
        sb.push_back(16'h0103);
        n_push++;
        @(negedge clk);
        bif.br_valid = 1'b0;
        wait_redirect("midrst");
        @(negedge clk);
        check("midrst/flush_before", bif.flush, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/flush", bif.flush, 0);
        check("midrst/rv", bif.redirect_valid, 0);
        check("midrst/cnt", taken_cnt, 0);
        check("midrst/ready", bif.br_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Saturating taken counter
        force dut.taken_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.taken_cnt_q;
        check("sat/preload", taken_cnt, 16'hFFFF);
        take_branch("sat", 3'b010, 16'h2000, 9'h0FF, 16'h2100);
        check("sat/cnt", taken_cnt, 16'hFFFF);

        // Scoreboard drained and every redirect was a single-cycle pulse
        check("end/sb_empty", sb.size(), 0);
        check("end/pulses", n_pulse, n_push);
        check("end/double", n_double, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
